ip_codma_ch_sched: RTL and testbench
====================================

// Module: ip_codma_ch_sched
// PURPOSE
//  Multi-channel task scheduler for the CODMA engine. Generalises the single-task DMA front end
//  to NUM_CH independent channels, each with its own start, task pointer, IRQ and error status.
//  Pending channels are arbitrated round-robin onto the one shared read/CRC/write engine.
//  Sits between the register/CPU interface and the engine control FSM.
// PARAMETERS
//  NUM_CH       4     number of channels, 2..16
//  ADDR_W       32    task-descriptor pointer width
//  TIMEOUT_CYC  1024  engine watchdog limit in ACTIVE cycles (CODMA_TIMEOUT_EN only), >=2
// PORTS
//  clk             in   1              clock; all logic on rising edge
//  reset           in   1              synchronous, active-high reset
//  ch_start_i      in   NUM_CH         per-channel 1-cycle start pulse
//  ch_task_ptr_i   in   NUM_CH*ADDR_W  per-channel descriptor pointer, sampled with start
//  ch_err_clr_i    in   NUM_CH         per-channel error clear pulse
//  ch_busy_o       out  NUM_CH         channel PENDING or ACTIVE
//  ch_irq_o        out  NUM_CH         1-cycle completion pulse
//  ch_err_o        out  NUM_CH         sticky error flag, high while channel in CH_ERROR
//  eng_req_o       out  1              engine request
//  eng_ch_o        out  CH_W           granted channel index, CH_W=$clog2(NUM_CH)
//  eng_task_ptr_o  out  ADDR_W         granted channel's descriptor pointer
//  eng_ack_i       in   1              engine accepted request
//  eng_done_i      in   1              engine finished current task
//  eng_err_i       in   1              engine finished with error
//  eng_abort_o     out  1              1-cycle abort pulse to engine (timeout)
// BEHAVIOUR
//  - Reset: all channels CH_IDLE; every output 0; rr pointer = NUM_CH-1 (ch0 wins first); wdog=0.
//  - Per channel ch_state_t: CH_IDLE -> CH_PENDING on start (ptr latched);
//    CH_PENDING -> CH_ACTIVE on eng_ack_i while granted;
//    CH_ACTIVE -> CH_IDLE on eng_done_i (ch_irq_o pulses next cycle);
//    CH_ACTIVE -> CH_ERROR on eng_err_i or timeout; CH_ERROR -> CH_IDLE on ch_err_clr_i.
//  - Start in any non-IDLE state ignored; latched pointer unchanged. Start+clr same cycle in
//    CH_ERROR: clear applies, start dropped.
//  - Arbitration only when no channel PENDING-granted or ACTIVE. Winner = first PENDING channel
//    after rr pointer, wrapping NUM_CH-1 -> 0. rr pointer updates to winner on ack.
//  - eng_req_o registered: rises the cycle after arbitration; eng_ch_o/eng_task_ptr_o stable
//    and eng_req_o held high until eng_ack_i; eng_req_o drops the cycle after ack.
//  - Latency: start on idle block -> eng_req_o high 2 cycles later.
//  - Back-to-back: done at cycle N -> next eng_req_o at N+2.
//  - eng_done_i and eng_err_i together: error wins, no IRQ.
//  - done/err/ack outside the expected state are ignored.
//  - Reset mid-task: state discarded, no IRQ, engine must be reset alongside.
// CONFIGURATION
//  CODMA_TIMEOUT_EN defined:
//  - wdog counter clears on entry to CH_ACTIVE and increments each ACTIVE cycle.
//  - At wdog==TIMEOUT_CYC-1 with no done/err: eng_abort_o pulses 1 cycle, channel -> CH_ERROR.
//  - done/err in that same cycle take precedence over timeout.
//  CODMA_TIMEOUT_EN undefined: no counter; eng_abort_o tied 0; TIMEOUT_CYC unused.
// STRUCTURE
//  - ip_codma_pkg gains ch_state_t (CH_IDLE, CH_PENDING, CH_ACTIVE, CH_ERROR, 2 bits) and
//    CODMA_MAX_CH=16.
//  - Sub-module ip_codma_rr_arb: combinational round-robin pick from a pending vector and
//    pointer -> one-hot grant + index + valid.
// TESTING
//  1. Reset, start ch2 ptr=0x1000 -> eng_req_o=1 ch=2 ptr=0x1000 at +2 cyc; ack; done -> ch_irq_o[2] 1 cyc.
//  2. Start ch0..3 together -> grant order 0,1,2,3; then restart 0,3 -> order 0,3 (rr after 3).
//  3. eng_req_o held 5 cyc without ack -> ch/ptr stable; second start on ch1 ignored, ptr kept.
//  4. eng_done_i & eng_err_i same cycle -> ch_err_o=1, no IRQ; start ignored until ch_err_clr_i.
//  5. TIMEOUT_EN, TIMEOUT_CYC=8, no done -> eng_abort_o pulse after 8 ACTIVE cycles, ch_err_o=1.
//  6. reset asserted while ACTIVE -> next cycle all outputs 0, all states CH_IDLE.

Source files
------------

// File: rtl/ip_codma_pkg.sv
// CODMA shared types: per-channel scheduler state and channel-count limit.
// Imported by the scheduler top and its round-robin arbiter.
package ip_codma_pkg;

  localparam int CODMA_MAX_CH = 16;

  typedef enum logic [1:0] {
    CH_IDLE    = 2'd0,
    CH_PENDING = 2'd1,
    CH_ACTIVE  = 2'd2,
    CH_ERROR   = 2'd3
  } ch_state_t;

endpackage

// File: rtl/ip_codma_rr_arb.sv
// CODMA round-robin pick: first set bit of pend_i after ptr_i, wrapping.
// Ports: pend_i/ptr_i in; gnt_o one-hot, idx_o index, vld_o any pending.
module ip_codma_rr_arb #(
  parameter int N = 4,
  parameter int W = $clog2(N)
) (
  input  logic [N-1:0] pend_i,
  input  logic [W-1:0] ptr_i,
  output logic [N-1:0] gnt_o,
  output logic [W-1:0] idx_o,
  output logic         vld_o
);

  int         c;
  logic [W-1:0] ci;

  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    vld_o = 1'b0;
    c     = 0;
    ci    = '0;
    for (int k = 1; k <= N; k++) begin
      c  = (int'(ptr_i) + k) % N;
      ci = W'(c);
      if (!vld_o && pend_i[ci]) begin
        vld_o     = 1'b1;
        gnt_o[ci] = 1'b1;
        idx_o     = ci;
      end
    end
  end

endmodule

// File: rtl/ip_codma_ch_sched.sv
// CODMA multi-channel scheduler: per-channel start/IRQ/error, round-robin
// grant onto one shared engine. Optional watchdog: CODMA_TIMEOUT_EN.
// Ports: ch_start_i/ch_task_ptr_i/ch_err_clr_i per channel; ch_busy_o,
// ch_irq_o, ch_err_o status; eng_req_o/eng_ch_o/eng_task_ptr_o request,
// eng_ack_i/eng_done_i/eng_err_i engine replies, eng_abort_o watchdog kill.
module ip_codma_ch_sched #(
  parameter  int NUM_CH      = 4,
  parameter  int ADDR_W      = 32,
  parameter  int TIMEOUT_CYC = 1024,
  localparam int CH_W        = $clog2(NUM_CH)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_CH-1:0]        ch_start_i,
  input  logic [NUM_CH*ADDR_W-1:0] ch_task_ptr_i,
  input  logic [NUM_CH-1:0]        ch_err_clr_i,
  output logic [NUM_CH-1:0]        ch_busy_o,
  output logic [NUM_CH-1:0]        ch_irq_o,
  output logic [NUM_CH-1:0]        ch_err_o,
  output logic                     eng_req_o,
  output logic [CH_W-1:0]          eng_ch_o,
  output logic [ADDR_W-1:0]        eng_task_ptr_o,
  input  logic                     eng_ack_i,
  input  logic                     eng_done_i,
  input  logic                     eng_err_i,
  output logic                     eng_abort_o
);

  import ip_codma_pkg::*;

  ch_state_t         st_q  [NUM_CH];
  ch_state_t         st_d  [NUM_CH];
  logic [ADDR_W-1:0] ptr_q [NUM_CH];
  logic [ADDR_W-1:0] ptr_d [NUM_CH];

  logic [NUM_CH-1:0] irq_q, irq_d;
  logic [NUM_CH-1:0] pend, gnt;
  logic              req_q, req_d;
  logic              abort_q, abort_d;
  logic [CH_W-1:0]   ch_q, ch_d;
  logic [CH_W-1:0]   rr_q, rr_d;
  logic [CH_W-1:0]   arb_idx;
  logic [ADDR_W-1:0] eptr_q, eptr_d;
  logic [ADDR_W-1:0] gnt_ptr;
  logic              any_act, arb_vld, acc, tmo;

  assign acc = req_q & eng_ack_i;

  always_comb begin
    pend      = '0;
    any_act   = 1'b0;
    ch_busy_o = '0;
    ch_err_o  = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      pend[i]      = (st_q[i] == CH_PENDING);
      any_act      = any_act | (st_q[i] == CH_ACTIVE);
      ch_busy_o[i] = (st_q[i] == CH_PENDING) |
                     (st_q[i] == CH_ACTIVE);
      ch_err_o[i]  = (st_q[i] == CH_ERROR);
    end
  end

  ip_codma_rr_arb #(
    .N (NUM_CH),
    .W (CH_W)
  ) u_arb (
    .pend_i (pend),
    .ptr_i  (rr_q),
    .gnt_o  (gnt),
    .idx_o  (arb_idx),
    .vld_o  (arb_vld)
  );

  always_comb begin
    gnt_ptr = '0;
    for (int i = 0; i < NUM_CH; i++)
      if (gnt[i]) gnt_ptr = gnt_ptr | ptr_q[i];
  end

`ifdef CODMA_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYC);
  logic [WD_W-1:0] wdog_q, wdog_d;

  always_comb begin
    wdog_d = wdog_q;
    if (acc)
      wdog_d = '0;
    else if (any_act)
      wdog_d = wdog_q + WD_W'(1);
  end

  // done/err in the limit cycle beat the watchdog
  assign tmo = any_act &&
               (wdog_q == WD_W'(TIMEOUT_CYC - 1)) &&
               !eng_done_i && !eng_err_i;

  always_ff @(posedge clk) begin
    if (reset) wdog_q <= '0;
    else       wdog_q <= wdog_d;
  end
`else
  assign tmo = 1'b0;
`endif

  always_comb begin
    irq_d   = '0;
    abort_d = tmo;
    for (int i = 0; i < NUM_CH; i++) begin
      st_d[i]  = st_q[i];
      ptr_d[i] = ptr_q[i];
      unique case (st_q[i])
        CH_IDLE: begin
          if (ch_start_i[i]) begin
            st_d[i]  = CH_PENDING;
            ptr_d[i] = ch_task_ptr_i[i*ADDR_W +: ADDR_W];
          end
        end
        CH_PENDING: begin
          if (acc && ch_q == CH_W'(i))
            st_d[i] = CH_ACTIVE;
        end
        CH_ACTIVE: begin
          if (eng_err_i || tmo) begin
            st_d[i] = CH_ERROR;
          end else if (eng_done_i) begin
            st_d[i]  = CH_IDLE;
            irq_d[i] = 1'b1;
          end
        end
        CH_ERROR: begin
          if (ch_err_clr_i[i])
            st_d[i] = CH_IDLE;
        end
        default: st_d[i] = CH_IDLE;
      endcase
    end
  end

  // grant is only re-evaluated when the engine is fully free
  always_comb begin
    req_d  = req_q;
    ch_d   = ch_q;
    eptr_d = eptr_q;
    rr_d   = rr_q;
    if (acc) begin
      req_d = 1'b0;
      rr_d  = ch_q;
    end else if (!req_q && !any_act && arb_vld) begin
      req_d  = 1'b1;
      ch_d   = arb_idx;
      eptr_d = gnt_ptr;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_CH; i++) begin
        st_q[i]  <= CH_IDLE;
        ptr_q[i] <= '0;
      end
      irq_q   <= '0;
      req_q   <= 1'b0;
      abort_q <= 1'b0;
      ch_q    <= '0;
      eptr_q  <= '0;
      rr_q    <= CH_W'(NUM_CH - 1);
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        st_q[i]  <= st_d[i];
        ptr_q[i] <= ptr_d[i];
      end
      irq_q   <= irq_d;
      req_q   <= req_d;
      abort_q <= abort_d;
      ch_q    <= ch_d;
      eptr_q  <= eptr_d;
      rr_q    <= rr_d;
    end
  end

  assign ch_irq_o       = irq_q;
  assign eng_req_o      = req_q;
  assign eng_ch_o       = ch_q;
  assign eng_task_ptr_o = eptr_q;
  assign eng_abort_o    = abort_q;

endmodule

// File: tb/tb_ip_codma_ch_sched.sv
// Bench for ip_codma_ch_sched: directed stimulus, grant/IRQ scoreboard.
// Watchdog checks follow CODMA_TIMEOUT_EN.
module tb_ip_codma_ch_sched;

  localparam int NUM_CH = 4;
  localparam int ADDR_W = 32;
  localparam int TMO    = 8;
  localparam int CH_W   = 2;

  logic                     clk = 1'b0;
  logic                     reset = 1'b1;
  logic [NUM_CH-1:0]        ch_start_i = '0;
  logic [NUM_CH*ADDR_W-1:0] ch_task_ptr_i = '0;
  logic [NUM_CH-1:0]        ch_err_clr_i = '0;
  logic [NUM_CH-1:0]        ch_busy_o, ch_irq_o, ch_err_o;
  logic                     eng_req_o, eng_abort_o;
  logic [CH_W-1:0]          eng_ch_o;
  logic [ADDR_W-1:0]        eng_task_ptr_o;
  logic                     eng_ack_i = 1'b0;
  logic                     eng_done_i = 1'b0;
  logic                     eng_err_i = 1'b0;

  always #5 clk = ~clk;

  ip_codma_ch_sched #(
    .NUM_CH      (NUM_CH),
    .ADDR_W      (ADDR_W),
    .TIMEOUT_CYC (TMO)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .ch_start_i     (ch_start_i),
    .ch_task_ptr_i  (ch_task_ptr_i),
    .ch_err_clr_i   (ch_err_clr_i),
    .ch_busy_o      (ch_busy_o),
    .ch_irq_o       (ch_irq_o),
    .ch_err_o       (ch_err_o),
    .eng_req_o      (eng_req_o),
    .eng_ch_o       (eng_ch_o),
    .eng_task_ptr_o (eng_task_ptr_o),
    .eng_ack_i      (eng_ack_i),
    .eng_done_i     (eng_done_i),
    .eng_err_i      (eng_err_i),
    .eng_abort_o    (eng_abort_o)
  );

  int n_chk  = 0;
  int n_fail = 0;

  int          exp_ch_q  [$];
  logic [31:0] exp_ptr_q [$];
  logic [3:0]  exp_irq_q [$];
  bit          req_seen = 1'b0;

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // monitor: each new request and each IRQ pulse is popped and compared
  always @(negedge clk) begin
    if (reset) begin
      req_seen = 1'b0;
    end else begin
      if (eng_req_o && !req_seen) begin
        req_seen = 1'b1;
        if (exp_ch_q.size() == 0)
          chk("unexp_req", 64'(eng_req_o), 64'd0);
        else begin
          chk("gnt_ch", 64'(eng_ch_o), 64'(exp_ch_q.pop_front()));
          chk("gnt_ptr", 64'(eng_task_ptr_o),
              64'(exp_ptr_q.pop_front()));
        end
      end else if (!eng_req_o) begin
        req_seen = 1'b0;
      end
      if (ch_irq_o != '0) begin
        if (exp_irq_q.size() == 0)
          chk("unexp_irq", 64'(ch_irq_o), 64'd0);
        else
          chk("irq", 64'(ch_irq_o), 64'(exp_irq_q.pop_front()));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ptr(input int c, input logic [31:0] v);
    ch_task_ptr_i[c*ADDR_W +: ADDR_W] = v;
  endtask

  task automatic expect_gnt(input int c, input logic [31:0] p);
    exp_ch_q.push_back(c);
    exp_ptr_q.push_back(p);
  endtask

  task automatic start_ch(input logic [3:0] m);
    ch_start_i = m;
    tick();
    ch_start_i = '0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    tick();
  endtask

  task automatic wait_req();
    int n = 0;
    while (!eng_req_o && n < 20) begin
      tick();
      n++;
    end
    chk("req_wait", 64'(eng_req_o), 64'd1);
  endtask

  task automatic serve(input logic d, input logic e);
    wait_req();
    eng_ack_i = 1'b1;
    tick();
    eng_ack_i = 1'b0;
    chk("req_drop", 64'(eng_req_o), 64'd0);
    eng_done_i = d;
    eng_err_i  = e;
    tick();
    eng_done_i = 1'b0;
    eng_err_i  = 1'b0;
  endtask

  task automatic chk_all_zero(input string nm);
    chk({nm, "_busy"}, 64'(ch_busy_o), 64'd0);
    chk({nm, "_irq"}, 64'(ch_irq_o), 64'd0);
    chk({nm, "_err"}, 64'(ch_err_o), 64'd0);
    chk({nm, "_req"}, 64'(eng_req_o), 64'd0);
    chk({nm, "_ch"}, 64'(eng_ch_o), 64'd0);
    chk({nm, "_ptr"}, 64'(eng_task_ptr_o), 64'd0);
    chk({nm, "_abort"}, 64'(eng_abort_o), 64'd0);
  endtask

  initial begin
    tick();
    tick();
    chk_all_zero("rst");
    reset = 1'b0;
    tick();

    // 1: single channel, latency and IRQ
    set_ptr(2, 32'h1000);
    expect_gnt(2, 32'h1000);
    exp_irq_q.push_back(4'b0100);
    start_ch(4'b0100);
    chk("lat_1cyc", 64'(eng_req_o), 64'd0);
    chk("busy_pend", 64'(ch_busy_o), 64'h4);
    tick();
    chk("lat_2cyc", 64'(eng_req_o), 64'd1);
    serve(1'b1, 1'b0);
    tick();
    chk("irq_pulse", 64'(ch_irq_o), 64'd0);
    chk("busy_idle", 64'(ch_busy_o), 64'd0);

    // 2: all channels, then rr continues after ch3
    do_reset();
    for (int i = 0; i < 4; i++) begin
      set_ptr(i, 32'hA0 + i);
      expect_gnt(i, 32'hA0 + i);
      exp_irq_q.push_back(4'(1 << i));
    end
    start_ch(4'b1111);
    serve(1'b1, 1'b0);
    chk("b2b_n1", 64'(eng_req_o), 64'd0);
    tick();
    chk("b2b_n2", 64'(eng_req_o), 64'd1);
    for (int i = 1; i < 4; i++) serve(1'b1, 1'b0);
    set_ptr(0, 32'hB0);
    set_ptr(3, 32'hB3);
    expect_gnt(0, 32'hB0);
    expect_gnt(3, 32'hB3);
    exp_irq_q.push_back(4'b0001);
    exp_irq_q.push_back(4'b1000);
    start_ch(4'b1001);
    serve(1'b1, 1'b0);
    serve(1'b1, 1'b0);
    tick();

    // 3: request held without ack, restart ignored
    set_ptr(1, 32'h2000);
    expect_gnt(1, 32'h2000);
    start_ch(4'b0010);
    wait_req();
    for (int k = 0; k < 5; k++) begin
      if (k == 1) begin
        set_ptr(1, 32'hDEAD);
        ch_start_i = 4'b0010;
      end
      tick();
      ch_start_i = '0;
      chk("hold_req", 64'(eng_req_o), 64'd1);
      chk("hold_ch", 64'(eng_ch_o), 64'd1);
      chk("hold_ptr", 64'(eng_task_ptr_o), 64'h2000);
    end
    exp_irq_q.push_back(4'b0010);
    serve(1'b1, 1'b0);
    tick();
    tick();
    chk("no_rerun_req", 64'(eng_req_o), 64'd0);
    chk("no_rerun_busy", 64'(ch_busy_o), 64'd0);

    // 4: done+err together -> error, no IRQ
    set_ptr(3, 32'h3000);
    expect_gnt(3, 32'h3000);
    start_ch(4'b1000);
    serve(1'b1, 1'b1);
    chk("err_set", 64'(ch_err_o), 64'h8);
    chk("err_busy", 64'(ch_busy_o), 64'd0);
    chk("err_noirq", 64'(ch_irq_o), 64'd0);
    start_ch(4'b1000);
    chk("err_start_ign", 64'(ch_busy_o), 64'd0);
    chk("err_sticky", 64'(ch_err_o), 64'h8);
    ch_start_i   = 4'b1000;
    ch_err_clr_i = 4'b1000;
    tick();
    ch_start_i   = '0;
    ch_err_clr_i = '0;
    chk("clr_err", 64'(ch_err_o), 64'd0);
    chk("clr_start_drop", 64'(ch_busy_o), 64'd0);
    tick();
    chk("clr_no_req", 64'(eng_req_o), 64'd0);
    eng_done_i = 1'b1;
    eng_ack_i  = 1'b1;
    tick();
    eng_done_i = 1'b0;
    eng_ack_i  = 1'b0;
    chk("stray_irq", 64'(ch_irq_o), 64'd0);
    chk("stray_busy", 64'(ch_busy_o), 64'd0);
    set_ptr(3, 32'h3100);
    expect_gnt(3, 32'h3100);
    exp_irq_q.push_back(4'b1000);
    start_ch(4'b1000);
    serve(1'b1, 1'b0);
    tick();

    // 5: watchdog
    set_ptr(0, 32'h5000);
    expect_gnt(0, 32'h5000);
    start_ch(4'b0001);
    wait_req();
    eng_ack_i = 1'b1;
    tick();
    eng_ack_i = 1'b0;
    for (int k = 0; k < 7; k++) tick();
    chk("abort_early", 64'(eng_abort_o), 64'd0);
    tick();
`ifdef CODMA_TIMEOUT_EN
    chk("abort", 64'(eng_abort_o), 64'd1);
    chk("tmo_err", 64'(ch_err_o), 64'h1);
    tick();
    chk("abort_pulse", 64'(eng_abort_o), 64'd0);
    ch_err_clr_i = 4'b0001;
    tick();
    ch_err_clr_i = '0;
    chk("tmo_clr", 64'(ch_err_o), 64'd0);
`else
    chk("no_abort", 64'(eng_abort_o), 64'd0);
    chk("still_busy", 64'(ch_busy_o), 64'h1);
    exp_irq_q.push_back(4'b0001);
    eng_done_i = 1'b1;
    tick();
    eng_done_i = 1'b0;
`endif
    tick();

    // 6: reset while active
    set_ptr(1, 32'h6000);
    expect_gnt(1, 32'h6000);
    start_ch(4'b0010);
    wait_req();
    eng_ack_i = 1'b1;
    tick();
    eng_ack_i = 1'b0;
    set_ptr(0, 32'h7000);
    start_ch(4'b0001);
    chk("pre_rst_busy", 64'(ch_busy_o), 64'h3);
    reset = 1'b1;
    tick();
    chk_all_zero("midrst");
    reset = 1'b0;
    tick();
    tick();
    chk("post_rst_req", 64'(eng_req_o), 64'd0);

    chk("sb_gnt_left", 64'(exp_ch_q.size()), 64'd0);
    chk("sb_irq_left", 64'(exp_irq_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule
